// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the ID stage control outputs and instruction memory.
// The master modport is the fetch stage; slave is the ID/memory side that drives it.
interface fetch_stage_if;
    logic        Stall;
    logic        Jump;
    logic        Branch;
    logic        Zero;
    logic [25:0] JumpIndex;
    logic [15:0] BranchImm;
    logic [31:0] IdPCPlus4;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] InstrOut;
    logic [31:0] PCPlus4Out;
    logic [5:0]  Opcode;
    logic        Valid;

    modport master (
        input  Stall, Jump, Branch, Zero, JumpIndex, BranchImm, IdPCPlus4, ImemAck, ImemData,
        output ImemReq, ImemAddr, InstrOut, PCPlus4Out, Opcode, Valid
    );

    modport slave (
        output Stall, Jump, Branch, Zero, JumpIndex, BranchImm, IdPCPlus4, ImemAck, ImemData,
        input  ImemReq, ImemAddr, InstrOut, PCPlus4Out, Opcode, Valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, stall hold buffer and
// jump/branch redirect with a drain state for an in-flight memory read.
//
// state | meaning
// FETCH | requesting word at PC, accepting it into IF/ID when ID is ready
// HOLD  | fetched word parked in hold buffer while ID stalls, no request
// DRAIN | redirect arrived mid-read; wait for that read to finish, then jump
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          Clock,
    input  logic          Reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pcp4_q, hold_pcp4_d;
    logic [31:0] redir_q, redir_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {bus.IdPCPlus4[31:28], bus.JumpIndex, 2'b00};
    assign branch_target = bus.IdPCPlus4 + {{14{bus.BranchImm[15]}}, bus.BranchImm, 2'b00};
    assign redirect      = !bus.Stall && (bus.Jump || (bus.Branch && bus.Zero));
    assign target        = bus.Jump ? jump_target : branch_target;

    assign bus.ImemReq    = !Reset && (state_q != HOLD);
    assign bus.ImemAddr   = pc_q;
    assign bus.InstrOut   = instr_q;
    assign bus.PCPlus4Out = pcp4_q;
    assign bus.Valid      = valid_q;
    assign bus.Opcode     = instr_q[31:26];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pcp4_d  = hold_pcp4_q;
        redir_d      = redir_q;

        case (state_q)
            FETCH: begin
                if (bus.ImemAck) begin
                    if (bus.Stall) begin
                        hold_instr_d = bus.ImemData;
                        hold_pcp4_d  = pc_plus4;
                        state_d      = HOLD;
                    end else if (redirect) begin
                        pc_d    = target;
                        instr_d = '0;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.ImemData;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (!bus.Stall) begin
                    if (redirect) begin
                        // Memory is mid-read at PC; keep the address stable until it completes.
                        redir_d = target;
                        instr_d = '0;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (!bus.Stall) begin
                    state_d = FETCH;
                    if (redirect) begin
                        pc_d    = target;
                        instr_d = '0;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = hold_instr_q;
                        pcp4_d  = hold_pcp4_q;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end
            end
            DRAIN: begin
                if (bus.ImemAck) begin
                    pc_d    = redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
            hold_instr_q <= '0;
            hold_pcp4_q  <= '0;
            redir_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pcp4_q  <= hold_pcp4_d;
            redir_q      <= redir_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/wrap sequences and a random
// run, all checked against a queue-based reference model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          stall, jump, branch, zero;
        logic [25:0] ji;
        logic [15:0] bi;
        logic [31:0] idp4;
        bit          ack;
        logic [31:0] e_addr;
        bit          e_req, e_valid;
        logic [31:0] e_instr, e_pcp4;
    } vec_t;

    vec_t tbl[17];

    // Reference model state: hold buffer and pending redirect kept as queues.
    logic [31:0] m_pc, m_instr, m_pcp4;
    bit          m_valid;
    logic [63:0] hold_buf[$];
    logic [31:0] pend_tgt[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic vec_t mk(input bit s, j, b, z, input logic [25:0] ji, input logic [15:0] bi,
                                input logic [31:0] ip, input bit a, input logic [31:0] ea,
                                input bit er, ev, input logic [31:0] ei, ep);
        vec_t v;
        v.stall = s; v.jump = j; v.branch = b; v.zero = z;
        v.ji = ji; v.bi = bi; v.idp4 = ip; v.ack = a;
        v.e_addr = ea; v.e_req = er; v.e_valid = ev; v.e_instr = ei; v.e_pcp4 = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = '0; m_pcp4 = '0; m_valid = 1'b0;
        hold_buf.delete();
        pend_tgt.delete();
    endtask

    task automatic model_flush();
        m_instr = '0; m_pcp4 = '0; m_valid = 1'b0;
    endtask

    task automatic model_edge(input bit stall, jump, branch, zero, input logic [25:0] ji,
                              input logic [15:0] bi, input logic [31:0] idp4, input bit ack,
                              input logic [31:0] data);
        bit          redir;
        logic [31:0] tgt;
        logic [63:0] hb;
        redir = !stall && (jump || (branch && zero));
        tgt = jump ? {idp4[31:28], ji, 2'b00} : idp4 + 32'(int'($signed(bi)) * 4);
        if (pend_tgt.size() > 0) begin
            if (ack) m_pc = pend_tgt.pop_front();
        end else if (hold_buf.size() > 0) begin
            if (!stall) begin
                hb = hold_buf.pop_front();
                if (redir) begin model_flush(); m_pc = tgt; end
                else begin
                    m_instr = hb[63:32]; m_pcp4 = hb[31:0]; m_valid = 1'b1; m_pc = m_pc + 32'd4;
                end
            end
        end else if (ack) begin
            if (stall) hold_buf.push_back({data, m_pc + 32'd4});
            else if (redir) begin model_flush(); m_pc = tgt; end
            else begin
                m_instr = data; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (!stall) begin
            if (redir) begin model_flush(); pend_tgt.push_back(tgt); end
            else begin m_instr = '0; m_valid = 1'b0; end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"},    32'(bus.ImemReq), 32'(!Reset && hold_buf.size() == 0));
        chk({tag, ".addr"},   bus.ImemAddr, m_pc);
        chk({tag, ".instr"},  bus.InstrOut, m_instr);
        chk({tag, ".pcp4"},   bus.PCPlus4Out, m_pcp4);
        chk({tag, ".valid"},  32'(bus.Valid), 32'(m_valid));
        chk({tag, ".opcode"}, 32'(bus.Opcode), 32'(m_instr[31:26]));
    endtask

    task automatic tick(input string tag, input bit rst, stall, jump, branch, zero,
                        input logic [25:0] ji, input logic [15:0] bi, input logic [31:0] idp4,
                        input bit ack);
        logic [31:0] data;
        data = ack ? word_at(m_pc) : $urandom;
        Reset = rst;
        bus.Stall = stall; bus.Jump = jump; bus.Branch = branch; bus.Zero = zero;
        bus.JumpIndex = ji; bus.BranchImm = bi; bus.IdPCPlus4 = idp4;
        bus.ImemAck = ack; bus.ImemData = data;
        @(posedge Clock);
        if (rst) model_reset();
        else model_edge(stall, jump, branch, zero, ji, bi, idp4, ack, data);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req"},   32'(bus.ImemReq), 32'd0);
        chk({tag, ".addr"},  bus.ImemAddr, RESET_PC);
        chk({tag, ".instr"}, bus.InstrOut, 32'd0);
        chk({tag, ".pcp4"},  bus.PCPlus4Out, 32'd0);
        chk({tag, ".valid"}, 32'(bus.Valid), 32'd0);
        chk({tag, ".op"},    32'(bus.Opcode), 32'd0);
    endtask

    initial begin
        bus.Stall = 0; bus.Jump = 0; bus.Branch = 0; bus.Zero = 0;
        bus.JumpIndex = '0; bus.BranchImm = '0; bus.IdPCPlus4 = '0;
        bus.ImemAck = 0; bus.ImemData = '0;
        model_reset();

        // Directed table: streaming, stall hold, bubble, jump, branch with drain, priority.
        tbl[0]  = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 1, 32'h4,  1, 1, word_at(32'h0), 32'h4);
        tbl[1]  = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 1, 32'h8,  1, 1, word_at(32'h4), 32'h8);
        tbl[2]  = mk(1,0,0,0, 26'h0, 16'h0, 32'h0, 1, 32'h8,  0, 1, word_at(32'h4), 32'h8);
        tbl[3]  = mk(1,0,0,0, 26'h0, 16'h0, 32'h0, 0, 32'h8,  0, 1, word_at(32'h4), 32'h8);
        tbl[4]  = mk(1,0,0,0, 26'h0, 16'h0, 32'h0, 0, 32'h8,  0, 1, word_at(32'h4), 32'h8);
        tbl[5]  = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 0, 32'hC,  1, 1, word_at(32'h8), 32'hC);
        tbl[6]  = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 1, 32'h10, 1, 1, word_at(32'hC), 32'h10);
        tbl[7]  = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 0, 32'h10, 1, 0, 32'h0, 32'h10);
        tbl[8]  = mk(0,1,0,0, 26'h0000040, 16'h0, 32'h0040_0010, 1, 32'h0000_0100, 1, 0, 32'h0, 32'h0);
        tbl[9]  = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 1, 32'h104, 1, 1, word_at(32'h100), 32'h104);
        tbl[10] = mk(0,0,1,1, 26'h0, 16'hFFFE, 32'h20, 0, 32'h104, 1, 0, 32'h0, 32'h0);
        tbl[11] = mk(0,1,0,0, 26'h3FF, 16'h0, 32'h0, 0, 32'h104, 1, 0, 32'h0, 32'h0);
        tbl[12] = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 1, 32'h18, 1, 0, 32'h0, 32'h0);
        tbl[13] = mk(0,0,1,0, 26'h0, 16'hFFFE, 32'h20, 1, 32'h1C, 1, 1, word_at(32'h18), 32'h1C);
        tbl[14] = mk(0,1,1,1, 26'h80, 16'h4, 32'h3000_0000, 1, 32'h3000_0200, 1, 0, 32'h0, 32'h0);
        tbl[15] = mk(1,1,1,1, 26'h80, 16'h4, 32'h3000_0000, 1, 32'h3000_0200, 0, 0, 32'h0, 32'h0);
        tbl[16] = mk(0,0,0,0, 26'h0, 16'h0, 32'h0, 0, 32'h3000_0204, 1, 1, word_at(32'h3000_0200), 32'h3000_0204);

        repeat (2) @(posedge Clock);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b0;
        #1;
        chk("post_reset.req",  32'(bus.ImemReq), 32'd1);
        chk("post_reset.addr", bus.ImemAddr, RESET_PC);

        for (int i = 0; i < 17; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            tick(t, 0, tbl[i].stall, tbl[i].jump, tbl[i].branch, tbl[i].zero,
                 tbl[i].ji, tbl[i].bi, tbl[i].idp4, tbl[i].ack);
            chk({t, ".e_addr"},  bus.ImemAddr, tbl[i].e_addr);
            chk({t, ".e_req"},   32'(bus.ImemReq), 32'(tbl[i].e_req));
            chk({t, ".e_valid"}, 32'(bus.Valid), 32'(tbl[i].e_valid));
            chk({t, ".e_instr"}, bus.InstrOut, tbl[i].e_instr);
            chk({t, ".e_pcp4"},  bus.PCPlus4Out, tbl[i].e_pcp4);
        end

        // Reset arriving while parked in HOLD takes effect without a clock edge.
        tick("hold_in", 0, 1, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1);
        chk("hold_in.req_low", 32'(bus.ImemReq), 32'd0);
        #2 Reset = 1'b1;
        #1 check_reset_outputs("hold_rst");
        model_reset();
        @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
        chk("hold_rel.req",  32'(bus.ImemReq), 32'd1);
        chk("hold_rel.addr", bus.ImemAddr, RESET_PC);

        // Reset arriving while draining a redirect.
        tick("drn_a", 0, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1);
        tick("drn_b", 0, 0, 1, 0, 0, 26'h1234, 16'h0, 32'h0, 0);
        chk("drn_b.addr_held", bus.ImemAddr, 32'h4);
        #2 Reset = 1'b1;
        #1 check_reset_outputs("drn_rst");
        model_reset();
        @(posedge Clock);
        #1 Reset = 1'b0;

        // PC+4 wrap at the top of the address space.
        tick("wrap_a", 0, 0, 1, 0, 0, 26'h3FF_FFFF, 16'h0, 32'hF000_0000, 1);
        chk("wrap_a.addr", bus.ImemAddr, 32'hFFFF_FFFC);
        tick("wrap_b", 0, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1);
        chk("wrap_b.addr",  bus.ImemAddr, 32'h0000_0000);
        chk("wrap_b.pcp4",  bus.PCPlus4Out, 32'h0000_0000);
        chk("wrap_b.instr", bus.InstrOut, word_at(32'hFFFF_FFFC));

        for (int n = 0; n < 800; n++) begin
            bit r, s, j, b, z, a;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 6) == 0);
            z = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 9) < 7);
            tick("rand", r, s, j, b, z, 26'($urandom), 16'($urandom), $urandom, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
